// File: rtl/qam_mapper_param.sv
// qam_mapper_param: serial-bit to Gray-coded QAM I/Q mapper (QPSK / 16-QAM / 64-QAM)
// with a one-deep valid/ready output register and an emitted-symbol counter.
module qam_mapper_param #(
  parameter int OUT_W = 8,
  parameter int SCALE = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    in_bit,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] I_out,
  output logic signed [OUT_W-1:0] Q_out,
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        sym_count,
  output logic                    mode_err
);

  localparam logic [1:0] MODE_QPSK  = 2'd0;
  localparam logic [1:0] MODE_QAM16 = 2'd1;
  localparam logic [1:0] MODE_QAM64 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  logic [2:0] bit_cnt;
  logic [4:0] acc;
  logic [1:0] mode_lat;

  logic       accept;
  logic       sym_done;
  logic [1:0] cur_mode;
  logic [2:0] last_idx;
  logic [5:0] acc_next;
  logic [2:0] i_bits;
  logic [2:0] q_bits;

  // Gray axis bits -> signed level (2n - (L-1)) * SCALE; unused upper Gray bits are zero
  function automatic logic signed [OUT_W-1:0] axis_level(input logic [2:0] g,
                                                          input logic [1:0] m);
    logic [2:0] n;
    int         lvl;
    n[2] = g[2];
    n[1] = g[2] ^ g[1];
    n[0] = n[1] ^ g[0];
    case (m)
      MODE_QAM16: lvl = 2 * int'(n) - 3;
      MODE_QAM64: lvl = 2 * int'(n) - 7;
      default:    lvl = 2 * int'(n) - 1;
    endcase
    return OUT_W'(lvl * SCALE);
  endfunction

  assign in_ready = !valid_out || out_ready;
  assign accept   = in_valid && in_ready;

  // Effective mode (fresh at symbol start, latched otherwise), symbol length and axis split
  always_comb begin
    cur_mode = mode_lat;
    if (bit_cnt == 3'd0) begin
      cur_mode = (mode == MODE_RSVD) ? MODE_QPSK : mode;
    end
    case (cur_mode)
      MODE_QAM16: last_idx = 3'd3;
      MODE_QAM64: last_idx = 3'd5;
      default:    last_idx = 3'd1;
    endcase
    acc_next = {acc, in_bit};
    case (cur_mode)
      MODE_QAM16: begin
        i_bits = {1'b0, acc_next[3:2]};
        q_bits = {1'b0, acc_next[1:0]};
      end
      MODE_QAM64: begin
        i_bits = acc_next[5:3];
        q_bits = acc_next[2:0];
      end
      default: begin
        i_bits = {2'b00, acc_next[1]};
        q_bits = {2'b00, acc_next[0]};
      end
    endcase
    sym_done = accept && (bit_cnt == last_idx);
  end

  // Bit accumulation, mode latch at symbol start and sticky reserved-mode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      acc      <= 5'd0;
      mode_lat <= MODE_QPSK;
      mode_err <= 1'b0;
    end else if (accept) begin
      acc <= acc_next[4:0];
      if (bit_cnt == 3'd0) begin
        mode_lat <= cur_mode;
        if (mode == MODE_RSVD) begin
          mode_err <= 1'b1;
        end
      end
      bit_cnt <= sym_done ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // One-deep output register: reload on symbol completion, otherwise drain on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      I_out     <= '0;
      Q_out     <= '0;
    end else if (sym_done) begin
      valid_out <= 1'b1;
      I_out     <= axis_level(i_bits, cur_mode);
      Q_out     <= axis_level(q_bits, cur_mode);
    end else if (out_ready) begin
      valid_out <= 1'b0;
    end
  end

  // Count symbols taken by downstream; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_count <= '0;
    end else if (valid_out && out_ready) begin
      sym_count <= sym_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_qam_mapper_param.sv
// Directed bench for qam_mapper_param: stimulus pushes expected I/Q into a scoreboard,
// a negedge monitor pops and compares on every output handshake.
module tb_qam_mapper_param;

  logic              clk;
  logic              reset;
  logic [1:0]        mode;
  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] I_out;
  logic signed [7:0] Q_out;
  logic              valid_out;
  logic              out_ready;
  logic [15:0]       sym_count;
  logic              mode_err;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_i[$];
  int exp_q[$];
  int cnt_model = 0;
  bit mon_en = 1'b0;

  qam_mapper_param #(.OUT_W(8), .SCALE(16), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .sym_count (sym_count),
    .mode_err  (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int i, input int q);
    exp_i.push_back(i);
    exp_q.push_back(q);
  endtask

  task automatic send(input logic b);
    int   n = 0;
    logic took;
    in_valid = 1'b1;
    in_bit   = b;
    do begin
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 50);
    if (!took) begin
      n_checks++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: sym_count model and scoreboard pop on output handshake
  always @(negedge clk) begin
    if (mon_en) begin
      check("sym_count_track", sym_count, cnt_model);
      if (reset) begin
        cnt_model = 0;
      end else if (valid_out && out_ready) begin
        if (exp_i.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_symbol: got I=%0d Q=%0d expected none", I_out, Q_out);
        end else begin
          check("sb_I", I_out, exp_i.pop_front());
          check("sb_Q", Q_out, exp_q.pop_front());
        end
        cnt_model = (cnt_model + 1) & 16'hFFFF;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mode = 2'd0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_valid", valid_out, 0);
    check("rst_I", I_out, 0);
    check("rst_Q", Q_out, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_mode_err", mode_err, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 16-QAM 1,0,1,1 -> +48/+16, valid one cycle after last bit
    mode = 2'd1;
    push(48, 16);
    send(1); send(0); send(1); send(1);
    in_valid = 1'b0;
    check("t1_valid_latency", valid_out, 1);
    check("t1_I", I_out, 48);
    check("t1_Q", Q_out, 16);
    idle(1);
    check("t1_sym_count", sym_count, 1);
    check("t1_valid_drained", valid_out, 0);

    // QPSK 0,1 then 64-QAM 1,0,0,1,1,0 back to back
    mode = 2'd0;
    push(-16, 16);
    send(0); send(1);
    mode = 2'd2;
    push(112, 16);
    send(1); send(0); send(0); send(1); send(1); send(0);
    idle(2);
    check("t2_sym_count", sym_count, 3);

    // Backpressure: output stalls, input blocked, then release
    mode = 2'd1;
    out_ready = 1'b0;
    push(-48, -48);
    send(0); send(0); send(0); send(0);
    in_bit = 1'b1;
    check("t3_in_ready_stall", in_ready, 0);
    check("t3_valid_stall", valid_out, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t3_in_ready_held", in_ready, 0);
    check("t3_I_held", I_out, -48);
    check("t3_Q_held", Q_out, -48);
    check("t3_sym_count_held", sym_count, 3);
    push(16, -16);
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    check("t3_sym_count_release", sym_count, 4);
    send(1); send(0); send(1);
    idle(2);
    check("t3_sym_count_end", sym_count, 5);

    // Mode change mid-symbol has no effect until next symbol
    mode = 2'd1;
    push(48, 16);
    send(1); send(0);
    mode = 2'd0;
    send(1);
    check("t4_not_done_3bits", valid_out, 0);
    send(1);
    check("t4_done_4bits", valid_out, 1);
    check("t4_I", I_out, 48);
    push(-16, -16);
    send(0);
    check("t4_qpsk_after_1bit", valid_out, 0);
    send(0);
    in_valid = 1'b0;
    check("t4_qpsk_after_2bits", valid_out, 1);
    check("t4_qpsk_I", I_out, -16);
    idle(2);
    check("t4_sym_count", sym_count, 7);

    // Reset after 3 bits of 64-QAM discards the partial symbol
    mode = 2'd2;
    send(1); send(1); send(1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_valid", valid_out, 0);
    check("t5_rst_I", I_out, 0);
    check("t5_rst_Q", Q_out, 0);
    check("t5_rst_sym_count", sym_count, 0);
    check("t5_rst_in_ready", in_ready, 1);
    reset = 1'b0;
    push(-112, -112);
    repeat (6) send(0);
    in_valid = 1'b0;
    check("t5_valid", valid_out, 1);
    check("t5_I", I_out, -112);
    check("t5_Q", Q_out, -112);
    idle(2);
    check("t5_sym_count", sym_count, 1);

    // Reserved mode: treated as QPSK, sticky error
    check("t6_err_before", mode_err, 0);
    mode = 2'd3;
    push(16, 16);
    send(1); send(1);
    mode = 2'd0;
    check("t6_err_set", mode_err, 1);
    push(-16, 16);
    send(0); send(1);
    idle(2);
    check("t6_err_sticky", mode_err, 1);
    check("t6_sym_count", sym_count, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_err_cleared", mode_err, 0);
    reset = 1'b0;
    idle(2);
    check("sb_queue_empty", exp_i.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
